// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC unit: next-PC select codes, FSM states and the
// sequential PC increment.
package fetch_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'b10;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JAL = 2'b11;
    localparam logic [1:0] PCSEL_JR  = 2'b00;

    localparam int unsigned PC_INC = 4;

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } fetch_state_e;

    // Counter width able to hold 0..cycles.
    function automatic int unsigned flush_cnt_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/fetch_flush_ctr.sv
// Flush hold counter: loads FLUSH_CYCLES-1, decrements towards zero and flags zero.
module fetch_flush_ctr
    import fetch_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int unsigned CNT_W = flush_cnt_w(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(FLUSH_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load wins over decrement; the counter saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch program counter: next-PC mux, PC register and RUN/FLUSH hold FSM.
// Define FETCH_PC_TRAP_EN to add the trap port and the TRAP_VEC redirect.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC    = ADDR_W'(32'h0000_0004),
    parameter int unsigned       FLUSH_CYCLES = 3,
    parameter logic [ADDR_W-1:0] TRAP_VEC     = ADDR_W'(32'h0000_0180)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
`ifdef FETCH_PC_TRAP_EN
    input  logic              trap,
`endif
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] pc_branch,
    input  logic [ADDR_W-1:0] pc_jal,
    input  logic [ADDR_W-1:0] pc_jr,
    input  logic              flush,
    output logic [ADDR_W-1:0] pc_if,
    output logic              pc_valid,
    output logic              flushing
);

    if (ADDR_W < 16 || ADDR_W > 64) begin : g_bad_addr_w
        $error("fetch_pc_unit: ADDR_W must be within 16..64");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("fetch_pc_unit: FLUSH_CYCLES must be within 1..15");
    end

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] sel_pc;
    logic              pc_valid_q, flushing_q;
    logic              ctr_load, ctr_dec, ctr_zero;

    always_comb begin
        sel_pc = pc_q;
        unique case (pc_sel)
            PCSEL_SEQ: sel_pc = pc_q + ADDR_W'(PC_INC);
            PCSEL_BR:  sel_pc = pc_branch;
            PCSEL_JAL: sel_pc = pc_jal;
            PCSEL_JR:  sel_pc = pc_jr;
            default:   sel_pc = pc_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (en) begin
                    pc_d = sel_pc;
                end
                if (flush) begin
                    state_d  = StFlush;
                    ctr_load = 1'b1;
                end
            end
            StFlush: begin
                // A fresh flush restarts the hold and lets the newest redirect through.
                if (flush) begin
                    ctr_load = 1'b1;
                    if (en) begin
                        pc_d = sel_pc;
                    end
                end else if (ctr_zero) begin
                    state_d = StRun;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
`ifdef FETCH_PC_TRAP_EN
        if (trap) begin
            pc_d     = TRAP_VEC;
            state_d  = StFlush;
            ctr_load = 1'b1;
            ctr_dec  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b1;
            flushing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= (state_d == StRun);
            flushing_q <= (state_d == StFlush);
        end
    end

    fetch_flush_ctr #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_flush_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(ctr_load),
        .dec_i (ctr_dec),
        .zero_o(ctr_zero)
    );

    assign pc_if    = pc_q;
    assign pc_valid = pc_valid_q;
    assign flushing = flushing_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table, corner sequences and
// randomized stimulus against a hold-count reference model.
module tb_fetch_pc_unit;

    localparam logic [1:0] SEQ = 2'b10;
    localparam logic [1:0] BR  = 2'b01;
    localparam logic [1:0] JAL = 2'b11;
    localparam logic [1:0] JR  = 2'b00;
    localparam int         FC  = 3;
    localparam logic [31:0] RST_PC  = 32'h0000_0004;
    localparam logic [31:0] TRAP_PC = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        trap = 1'b0;
    logic [1:0]  pc_sel = SEQ;
    logic [31:0] pc_branch = '0, pc_jal = '0, pc_jr = '0;
    logic        flush = 1'b0;
    logic [31:0] pc_if;
    logic        pc_valid, flushing;

    logic        en16 = 1'b0;
    logic [1:0]  sel16 = SEQ;
    logic [15:0] tgt16 = '0;
    logic [15:0] pc16_if;
    logic        pc16_valid, pc16_flushing;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
`ifdef FETCH_PC_TRAP_EN
        .trap     (trap),
`endif
        .pc_sel   (pc_sel),
        .pc_branch(pc_branch),
        .pc_jal   (pc_jal),
        .pc_jr    (pc_jr),
        .flush    (flush),
        .pc_if    (pc_if),
        .pc_valid (pc_valid),
        .flushing (flushing)
    );

    fetch_pc_unit #(
        .ADDR_W   (16),
        .RESET_VEC(16'hFFFC)
    ) dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en16),
`ifdef FETCH_PC_TRAP_EN
        .trap     (1'b0),
`endif
        .pc_sel   (sel16),
        .pc_branch(tgt16),
        .pc_jal   (tgt16),
        .pc_jr    (tgt16),
        .flush    (1'b0),
        .pc_if    (pc16_if),
        .pc_valid (pc16_valid),
        .flushing (pc16_flushing)
    );

    // Reference model: PC plus the number of hold edges still owed.
    logic [31:0] m_pc;
    int          m_hold;

    function automatic logic [31:0] target(input logic [1:0] sel, input logic [31:0] pc);
        case (sel)
            SEQ:     return pc + 32'd4;
            BR:      return pc_branch;
            JAL:     return pc_jal;
            default: return pc_jr;
        endcase
    endfunction

    task automatic model_reset();
        m_pc   = RST_PC;
        m_hold = 0;
    endtask

    task automatic model_edge();
        if (trap) begin
            m_pc   = TRAP_PC;
            m_hold = FC;
        end else if (m_hold == 0) begin
            if (en) m_pc = target(pc_sel, m_pc);
            if (flush) m_hold = FC;
        end else if (flush) begin
            m_hold = FC;
            if (en) m_pc = target(pc_sel, m_pc);
        end else begin
            m_hold--;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic        flush;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        exp_flushing;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic e, input logic [1:0] s, input logic [31:0] t,
                                input logic f, input logic [31:0] p, input logic v,
                                input logic fl);
        vec_t r;
        r.en = e; r.sel = s; r.tgt = t; r.flush = f;
        r.exp_pc = p; r.exp_valid = v; r.exp_flushing = fl;
        return r;
    endfunction

    initial begin
        vecs[0]  = mk(1, SEQ, 0,     0, 32'h008, 1, 0);
        vecs[1]  = mk(1, SEQ, 0,     0, 32'h00C, 1, 0);
        vecs[2]  = mk(1, SEQ, 0,     0, 32'h010, 1, 0);
        vecs[3]  = mk(1, BR,  'h100, 1, 32'h100, 0, 1);
        vecs[4]  = mk(1, SEQ, 0,     0, 32'h100, 0, 1);
        vecs[5]  = mk(1, SEQ, 0,     0, 32'h100, 0, 1);
        vecs[6]  = mk(1, SEQ, 0,     0, 32'h100, 1, 0);
        vecs[7]  = mk(1, SEQ, 0,     0, 32'h104, 1, 0);
        vecs[8]  = mk(0, SEQ, 0,     0, 32'h104, 1, 0);
        vecs[9]  = mk(1, JR,  'h300, 0, 32'h300, 1, 0);
        vecs[10] = mk(1, BR,  'h100, 1, 32'h100, 0, 1);
        vecs[11] = mk(1, JAL, 'h200, 1, 32'h200, 0, 1);
        vecs[12] = mk(1, SEQ, 0,     0, 32'h200, 0, 1);
        vecs[13] = mk(1, SEQ, 0,     0, 32'h200, 0, 1);
        vecs[14] = mk(1, SEQ, 0,     0, 32'h200, 1, 0);
        vecs[15] = mk(1, SEQ, 0,     0, 32'h204, 1, 0);
        vecs[16] = mk(0, SEQ, 0,     1, 32'h204, 0, 1);
        vecs[17] = mk(0, SEQ, 0,     1, 32'h204, 0, 1);
        vecs[18] = mk(1, SEQ, 0,     0, 32'h204, 0, 1);
        vecs[19] = mk(1, SEQ, 0,     0, 32'h204, 0, 1);
        vecs[20] = mk(1, SEQ, 0,     0, 32'h204, 1, 0);
        vecs[21] = mk(1, SEQ, 0,     0, 32'h208, 1, 0);

        // Reset state
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        check("reset pc", pc_if, RST_PC);
        check("reset valid", pc_valid, 1'b1);
        check("reset flushing", flushing, 1'b0);
        check("reset pc16", pc16_if, 16'hFFFC);
        #20 rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 22; i++) begin
            en = vecs[i].en;
            pc_sel = vecs[i].sel;
            pc_branch = vecs[i].tgt;
            pc_jal = vecs[i].tgt;
            pc_jr = vecs[i].tgt;
            flush = vecs[i].flush;
            step();
            check($sformatf("vec%0d pc", i), pc_if, vecs[i].exp_pc);
            check($sformatf("vec%0d valid", i), pc_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d flushing", i), flushing, vecs[i].exp_flushing);
        end

        // Asynchronous reset in the middle of a flush
        en = 1'b1; pc_sel = BR; pc_branch = 32'h40; flush = 1'b1;
        step();
        check("midflush enter", flushing, 1'b1);
        flush = 1'b0; pc_sel = SEQ;
        step();
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check("async rst pc", pc_if, RST_PC);
        check("async rst flushing", flushing, 1'b0);
        check("async rst valid", pc_valid, 1'b1);
        #1 rst_n = 1'b1;
        step();
        check("post rst pc", pc_if, 32'h8);
        check("post rst valid", pc_valid, 1'b1);

        // Randomized stimulus against the model
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            pc_sel = 2'($urandom);
            pc_branch = $urandom;
            pc_jal = $urandom;
            pc_jr = $urandom;
            flush = ($urandom_range(0, 7) == 0);
`ifdef FETCH_PC_TRAP_EN
            trap = ($urandom_range(0, 31) == 0);
`endif
            step();
            check($sformatf("rnd%0d pc", i), pc_if, m_pc);
            check($sformatf("rnd%0d valid", i), pc_valid, m_hold == 0);
            check($sformatf("rnd%0d flushing", i), flushing, m_hold != 0);
        end
        flush = 1'b0;
        trap = 1'b0;

`ifdef FETCH_PC_TRAP_EN
        // Trap with EN low still redirects and holds for FC edges
        en = 1'b0; pc_sel = SEQ; trap = 1'b1;
        step();
        trap = 1'b0;
        check("trap pc", pc_if, TRAP_PC);
        check("trap flushing0", flushing, 1'b1);
        step();
        check("trap flushing1", flushing, 1'b1);
        step();
        check("trap flushing2", flushing, 1'b1);
        step();
        check("trap release", flushing, 1'b0);
        check("trap hold pc", pc_if, TRAP_PC);
`endif

        // 16-bit PC wraps to zero
        en = 1'b0;
        en16 = 1'b1;
        step();
        check("wrap16 pc", pc16_if, 16'h0000);
        step();
        check("wrap16 next", pc16_if, 16'h0004);
        check("wrap16 valid", pc16_valid, 1'b1);
        en16 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
